fifo_rd_ctrl: RTL and testbench

FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

---
 rtl/fifo_rd_ctrl.sv | 117 +++++++++++
 tb/tb_fifo_rd_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_ctrl.sv
// rtl/fifo_rd_ctrl.sv - FIFO read controller: 2-entry output buffer, stream output, burst framing.
// Optional m_par output (XOR of m_data) when FIFO_RD_PARITY_EN is defined.
module fifo_rd_ctrl #(
  parameter int BURST_LEN = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        empty,
  input  logic        error,
  input  logic [31:0] data_out,
  output logic        pop,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        m_last,
  output logic        rd_err
`ifdef FIFO_RD_PARITY_EN
  ,
  output logic        m_par
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [7:0] BCNT_LAST = 8'(BURST_LEN - 1);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] head_q;
  logic [31:0] tail_q;
  logic [1:0]  occ;
  logic        pend;
  logic [7:0]  bcnt;
  logic        hs;
  logic [1:0]  base;
  logic [2:0]  fill;

  assign hs      = m_valid & m_ready;
  assign m_valid = (occ != 2'd0);
  assign m_data  = head_q;
  assign m_last  = m_valid && (bcnt == BCNT_LAST);

  // Entries left after this cycle's handshake; the landing word goes right behind them.
  assign base = occ - {1'b0, hs};
  assign fill = {1'b0, base} + {2'b00, pend};

  // A pop is only issued if its word is guaranteed a slot when it lands next cycle.
  assign pop = reset_n && (state == RUN) && !empty && (fill <= 3'd1);

`ifdef FIFO_RD_PARITY_EN
  assign m_par = ^head_q;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN:     if (!enable) state_nxt = DRAIN;
      DRAIN: begin
        if (enable)
          state_nxt = RUN;
        else if ((occ == 2'd0) && !pend)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head_q <= 32'd0;
      tail_q <= 32'd0;
      occ    <= 2'd0;
      pend   <= 1'b0;
    end else begin
      pend <= pop;
      if (hs && (occ == 2'd2))
        head_q <= tail_q;
      if (pend) begin
        if (base == 2'd0)
          head_q <= data_out;
        else
          tail_q <= data_out;
      end
      occ <= base + {1'b0, pend};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bcnt <= 8'd0;
    end else if (hs) begin
      if (bcnt == BCNT_LAST)
        bcnt <= 8'd0;
      else
        bcnt <= bcnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_err <= 1'b0;
    end else if (error) begin
      rd_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb/tb_fifo_rd_ctrl.sv - scoreboard bench for fifo_rd_ctrl with a queue-based FIFO model.
module tb_fifo_rd_ctrl;
  localparam int BL = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        empty = 1'b1;
  logic        error = 1'b0;
  logic        m_ready = 1'b0;
  logic [31:0] data_out = 32'd0;
  logic        pop;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_last;
  logic        rd_err;
`ifdef FIFO_RD_PARITY_EN
  logic        m_par;
`endif

  fifo_rd_ctrl #(.BURST_LEN(BL)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .empty(empty), .error(error),
    .data_out(data_out), .pop(pop), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .rd_err(rd_err)
`ifdef FIFO_RD_PARITY_EN
    , .m_par(m_par)
`endif
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          hs_n = 0;
  int          last_cnt = 0;
  logic        pop_s = 1'b0;
  logic [31:0] fifo_q[$];
  logic [31:0] exp_q[$];
  int          pop_cyc[$];
  int          hs_cyc[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // One clock: sample pop at negedge, then the FIFO model answers just after the edge.
  task automatic step();
    @(negedge clk);
    pop_s = pop;
    if (pop) pop_cyc.push_back(cyc);
    @(posedge clk);
    #1;
    if (pop_s && fifo_q.size() > 0) begin
      data_out = fifo_q.pop_front();
      exp_q.push_back(data_out);
      empty = (fifo_q.size() == 0);
    end
  endtask

  task automatic load(input logic [31:0] w);
    fifo_q.push_back(w);
    empty = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    exp_q.delete();
    hs_n = 0;
    step();
    check("rst_pop", 32'(pop), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", m_data, 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_rd_err", 32'(rd_err), 32'd0);
`ifdef FIFO_RD_PARITY_EN
    check("rst_m_par", 32'(m_par), 32'd0);
`endif
    step();
    reset_n = 1'b1;
  endtask

  task automatic clear_logs();
    pop_cyc.delete();
    hs_cyc.delete();
    last_cnt = 0;
  endtask

  // Monitor: scoreboard pop/compare on every handshake, plus stall and capacity rules.
  initial begin
    logic        pv;
    logic        pr;
    logic        pl;
    logic [31:0] pd;
    logic [31:0] exp;
    int          outstanding;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = 32'd0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        pv = 1'b0;
      end else begin
        if (pop) begin
          check("pop_while_empty", 32'(empty), 32'd0);
          outstanding = exp_q.size() - int'(m_valid && m_ready) + 1;
          check("outstanding_le2", 32'(outstanding <= 2), 32'd1);
        end
        if (pv && !pr) begin
          check("stall_valid", 32'(m_valid), 32'd1);
          check("stall_data", m_data, pd);
          check("stall_last", 32'(m_last), 32'(pl));
        end
        if (m_last) check("last_without_valid", 32'(m_valid), 32'd1);
`ifdef FIFO_RD_PARITY_EN
        if (m_valid) check("m_par", 32'(m_par), 32'(^m_data));
`endif
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_word: got 0x%0h, required no word (t=%0t)", m_data, $time);
          end else begin
            exp = exp_q.pop_front();
            check("m_data", m_data, exp);
            check("m_last", 32'(m_last), 32'((hs_n % BL) == BL - 1));
          end
          if (m_last) last_cnt++;
          hs_n++;
          hs_cyc.push_back(cyc);
        end
        pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
      end
    end
  end

  initial begin
    int t0;
    int n;
    do_reset();

    // Three words, free-flowing: pops on consecutive cycles, words two cycles later.
    clear_logs();
    load(32'h11); load(32'h22); load(32'h33);
    m_ready = 1'b1;
    enable = 1'b1;
    t0 = cyc;
    repeat (8) step();
    check("t1_pops", 32'(pop_cyc.size()), 32'd3);
    check("t1_words", 32'(hs_cyc.size()), 32'd3);
    if (pop_cyc.size() == 3 && hs_cyc.size() == 3) begin
      check("t1_first_pop", 32'(pop_cyc[0]), 32'(t0 + 1));
      for (int i = 0; i < 3; i++) begin
        check("t1_pop_seq", 32'(pop_cyc[i]), 32'(t0 + 1 + i));
        check("t1_latency", 32'(hs_cyc[i]), 32'(pop_cyc[i] + 2));
      end
    end
    check("t1_no_last", 32'(last_cnt), 32'd0);

    // Sixteen words then one more: m_last on words 8 and 16 only.
    do_reset();
    clear_logs();
    for (int i = 0; i < 16; i++) load(32'h1000 + 32'(i));
    repeat (24) step();
    check("t2_words", 32'(hs_cyc.size()), 32'd16);
    check("t2_lasts", 32'(last_cnt), 32'd2);
    load(32'h2000);
    repeat (4) step();
    check("t2_wrap_words", 32'(hs_cyc.size()), 32'd17);
    check("t2_wrap_lasts", 32'(last_cnt), 32'd2);

    // Back-pressure: at most two pops while stalled, then in-order release.
    do_reset();
    clear_logs();
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) load($urandom);
    repeat (7) step();
    check("t3_stalled_pops", 32'(pop_cyc.size()), 32'd2);
    check("t3_stalled_words", 32'(hs_cyc.size()), 32'd0);
    m_ready = 1'b1;
    repeat (12) step();
    check("t3_words", 32'(hs_cyc.size()), 32'd6);
    check("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // Enable drops with a full buffer: no more pops, both words still delivered.
    do_reset();
    clear_logs();
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) load($urandom);
    repeat (5) step();
    check("t4_full_pops", 32'(pop_cyc.size()), 32'd2);
    enable = 1'b0;
    repeat (5) step();
    check("t4_no_pop_off", 32'(pop_cyc.size()), 32'd2);
    m_ready = 1'b1;
    repeat (4) step();
    check("t4_drained", 32'(hs_cyc.size()), 32'd2);
    check("t4_valid_low", 32'(m_valid), 32'd0);
    check("t4_still_no_pop", 32'(pop_cyc.size()), 32'd2);
    enable = 1'b1;
    repeat (8) step();
    check("t4_resume", 32'(hs_cyc.size()), 32'd4);

    // Sticky error flag, cleared only by reset.
    error = 1'b1;
    step();
    error = 1'b0;
    repeat (3) step();
    check("t5_rd_err_sticky", 32'(rd_err), 32'd1);
    do_reset();

    // Reset mid-stream: in-flight words dropped, framing restarts at word 0.
    clear_logs();
    m_ready = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 10; i++) load(32'h3000 + 32'(i));
    repeat (4) step();
    do_reset();
    repeat (14) step();
    check("t6_fifo_empty", 32'(fifo_q.size()), 32'd0);
    check("t6_sb_empty", 32'(exp_q.size()), 32'd0);

    // Random traffic.
    do_reset();
    enable = 1'b1;
    repeat (1500) begin
      m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 24) == 0) enable = ~enable;
      if ($urandom_range(0, 2) != 0 && fifo_q.size() < 32) load($urandom);
      if ($urandom_range(0, 599) == 0) do_reset();
      step();
    end
    enable = 1'b1;
    m_ready = 1'b1;
    n = 0;
    while ((fifo_q.size() + exp_q.size()) != 0 && n < 300) begin
      step();
      n++;
    end
    check("rand_drain_done", 32'(fifo_q.size() + exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
